binary_down_counter_par_load: RTL and testbench

Parameterised binary down counter with parallel load, reload register and borrow output; the counting-down companion to the team's 4-bit up counter with parallel load. Counts from a loaded value toward zero. On underflow it either wraps to all-ones or reloads a stored start value. It asserts a ripple borrow so stages cascade into wider down counters or programmable-period timers. It sits alongside the up counter in the register/counter library and uses the same load/count/clear control style.

---
 rtl/binary_down_counter_par_load.sv | 63 ++++++
 tb/tb_binary_down_counter_par_load.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/binary_down_counter_par_load.sv
// Parameterised binary down counter with parallel load, a reload register for
// auto-reload on underflow, and a combinational ripple borrow for cascading.
module binary_down_counter_par_load #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             Clear_b,
    input  logic [WIDTH-1:0] Data_in,
    input  logic             Load,
    input  logic             Count,
    input  logic             Auto_reload,
    output logic [WIDTH-1:0] A_count,
    output logic             B_out,
    output logic             Zero,
    output logic             Reloaded
);

    logic [WIDTH-1:0] a_count_d, a_count_q;
    logic [WIDTH-1:0] r_d, r_q;
    logic             reloaded_d, reloaded_q;
    logic             at_zero;

    assign at_zero = (a_count_q == '0);

    // Load beats counting; an underflow either wraps to all-ones or restarts from R.
    always_comb begin
        a_count_d  = a_count_q;
        r_d        = r_q;
        reloaded_d = 1'b0;
        if (Load) begin
            a_count_d = Data_in;
            r_d       = Data_in;
        end else if (Count) begin
            if (!at_zero) begin
                a_count_d = a_count_q - WIDTH'(1);
            end else if (Auto_reload) begin
                a_count_d  = r_q;
                reloaded_d = 1'b1;
            end else begin
                a_count_d = '1;
            end
        end
    end

    always_ff @(posedge CLK or negedge Clear_b) begin
        if (!Clear_b) begin
            a_count_q  <= '0;
            r_q        <= '0;
            reloaded_q <= 1'b0;
        end else begin
            a_count_q  <= a_count_d;
            r_q        <= r_d;
            reloaded_q <= reloaded_d;
        end
    end

    // Borrow is masked by Load so a cascaded upper stage never steps on a load edge.
    assign A_count  = a_count_q;
    assign Zero     = at_zero;
    assign B_out    = Count & ~Load & at_zero;
    assign Reloaded = reloaded_q;

endmodule

// File: tb/tb_binary_down_counter_par_load.sv
// Self-checking bench: a behavioural reference model compared on every falling
// edge, directed scenarios with literal expectations, randomized traffic, and a cascade.
module tb_binary_down_counter_par_load;

    localparam int WIDTH = 4;
    localparam int MAXV  = (1 << WIDTH) - 1;

    logic             clk = 1'b0;
    logic             clear_b = 1'b1;
    logic [WIDTH-1:0] data_in = '0;
    logic             load = 1'b0;
    logic             count = 1'b0;
    logic             auto_reload = 1'b0;
    logic [WIDTH-1:0] a_count;
    logic             b_out, zero, reloaded;

    logic [WIDTH-1:0] lo_data = 4'h0, hi_data = 4'h1;
    logic             casc_load = 1'b0, casc_count = 1'b0;
    logic [WIDTH-1:0] lo_count, hi_count;
    logic             lo_b_out, lo_zero, lo_reloaded;
    logic             hi_b_out, hi_zero, hi_reloaded;

    int vectors = 0;
    int miscompares = 0;
    bit check_en = 1'b0;

    int m_count = 0;
    int m_r = 0;
    bit m_reloaded = 1'b0;

    binary_down_counter_par_load #(.WIDTH(WIDTH)) dut (
        .CLK(clk), .Clear_b(clear_b), .Data_in(data_in), .Load(load),
        .Count(count), .Auto_reload(auto_reload), .A_count(a_count),
        .B_out(b_out), .Zero(zero), .Reloaded(reloaded)
    );

    binary_down_counter_par_load #(.WIDTH(WIDTH)) lo_stage (
        .CLK(clk), .Clear_b(clear_b), .Data_in(lo_data), .Load(casc_load),
        .Count(casc_count), .Auto_reload(1'b0), .A_count(lo_count),
        .B_out(lo_b_out), .Zero(lo_zero), .Reloaded(lo_reloaded)
    );

    binary_down_counter_par_load #(.WIDTH(WIDTH)) hi_stage (
        .CLK(clk), .Clear_b(clear_b), .Data_in(hi_data), .Load(casc_load),
        .Count(lo_b_out), .Auto_reload(1'b0), .A_count(hi_count),
        .B_out(hi_b_out), .Zero(hi_zero), .Reloaded(hi_reloaded)
    );

    // First rising edge at t=12, leaving t=5 free for a clockless reset check.
    initial begin
        #7;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: the counter as plain integer arithmetic modulo 2^WIDTH.
    always @(posedge clk or negedge clear_b) begin
        if (!clear_b) begin
            m_count    = 0;
            m_r        = 0;
            m_reloaded = 1'b0;
        end else begin
            m_reloaded = 1'b0;
            if (load) begin
                m_count = int'(data_in);
                m_r     = int'(data_in);
            end else if (count) begin
                if (m_count > 0) begin
                    m_count = m_count - 1;
                end else if (auto_reload) begin
                    m_count    = m_r;
                    m_reloaded = 1'b1;
                end else begin
                    m_count = MAXV;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("model_a_count", 32'(a_count), 32'(m_count));
            checkOutput("model_zero", 32'(zero), 32'(m_count == 0));
            checkOutput("model_b_out", 32'(b_out), 32'(count && !load && m_count == 0));
            checkOutput("model_reloaded", 32'(reloaded), 32'(m_reloaded));
        end
    end

    // Inputs change 2 units after the rising edge so they are stable at the next one.
    task automatic applyStimulus(input logic ld, input logic cnt, input logic ar,
                                 input logic [WIDTH-1:0] d);
        @(posedge clk);
        #2;
        load        = ld;
        count       = cnt;
        auto_reload = ar;
        data_in     = d;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        int exp_val;

        #5 clear_b = 1'b0;
        #1;
        checkOutput("reset_a_count", 32'(a_count), 32'd0);
        checkOutput("reset_zero", 32'(zero), 32'd1);
        checkOutput("reset_b_out", 32'(b_out), 32'd0);
        checkOutput("reset_reloaded", 32'(reloaded), 32'd0);
        check_en = 1'b1;
        #10 clear_b = 1'b1;

        $display("[TB] load 10 then count down with wrap");
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd10);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 4'd0);
            settle();
            exp_val = (10 - i + 16) % 16;
            checkOutput("wrap_seq_a_count", 32'(a_count), 32'(exp_val));
            checkOutput("wrap_seq_b_out", 32'(b_out), 32'(exp_val == 0));
        end
        checkOutput("wrap_to_15", 32'(a_count), 32'd15);

        $display("[TB] auto-reload from 3");
        applyStimulus(1'b1, 1'b0, 1'b1, 4'd3);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 4'd0);
            settle();
            checkOutput("reload_seq_a_count", 32'(a_count), 32'(3 - (i % 4)));
            checkOutput("reload_seq_pulse", 32'(reloaded), 32'(i > 0 && i % 4 == 0));
        end

        $display("[TB] load beats count at zero");
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd5);
        settle();
        checkOutput("priority_at_zero", 32'(a_count), 32'd0);
        checkOutput("priority_b_out", 32'(b_out), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0);
        settle();
        checkOutput("priority_loaded_5", 32'(a_count), 32'd5);

        $display("[TB] reset in the middle of auto-reload counting");
        applyStimulus(1'b1, 1'b0, 1'b1, 4'd10);
        applyStimulus(1'b0, 1'b1, 1'b1, 4'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 4'd0);
        @(negedge clk);
        #1 clear_b = 1'b0;
        #1;
        checkOutput("midreset_immediate", 32'(a_count), 32'd0);
        #13;
        checkOutput("midreset_held", 32'(a_count), 32'd0);
        #8 clear_b = 1'b1;
        settle();
        checkOutput("postreset_a_count", 32'(a_count), 32'd0);
        checkOutput("postreset_b_out", 32'(b_out), 32'd1);
        checkOutput("postreset_reloaded", 32'(reloaded), 32'd1);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 300; i++) begin
            applyStimulus(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 1)), WIDTH'($urandom_range(0, MAXV)));
            if ($urandom_range(0, 63) == 0) begin
                #1 clear_b = 1'b0;
                #1 clear_b = 1'b1;
            end
        end

        $display("[TB] two-stage cascade from 8'h10");
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0);
        casc_load = 1'b1;
        @(posedge clk);
        #2;
        casc_load  = 1'b0;
        casc_count = 1'b1;
        settle();
        checkOutput("cascade_10", 32'({hi_count, lo_count}), 32'h10);
        checkOutput("cascade_borrow", 32'(lo_b_out), 32'd1);
        settle();
        checkOutput("cascade_0F", 32'({hi_count, lo_count}), 32'h0F);
        settle();
        checkOutput("cascade_0E", 32'({hi_count, lo_count}), 32'h0E);
        checkOutput("cascade_hi_hold", 32'(hi_count), 32'd0);

        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
